// File: rtl/game_pace_ctrl_pkg.sv
// Shared game definitions: state encodings, playfield length and the ground
// scroll arithmetic, also used by the ground renderer.
package game_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int GROUND_LEN_DEF = 160;
  localparam int SPEED_MAX_DEF  = 8;

  // pos+spd < 2*len, so one conditional subtract is enough for the wrap
  function automatic logic [7:0] wrap_add(input logic [7:0] pos,
                                          input logic [3:0] spd,
                                          input logic [8:0] len);
    logic [8:0] sum;
    logic [8:0] res;
    sum = {1'b0, pos} + {5'd0, spd};
    res = (sum >= len) ? (sum - len) : sum;
    return res[7:0];
  endfunction

endpackage

// File: rtl/game_pace_ctrl_if.sv
// Pacing controller bus: frame/key/collision inputs and the shared scroll state.
interface game_pace_if;
  logic        fresh;
  logic        start;
  logic        collision;
  logic        game_status;
  logic        game_over;
  logic [7:0]  ground_position;
  logic [3:0]  speed;
  logic [15:0] score;

  modport master (
    output fresh, start, collision,
    input  game_status, game_over, ground_position, speed, score
  );

  modport slave (
    input  fresh, start, collision,
    output game_status, game_over, ground_position, speed, score
  );
endinterface

// File: rtl/game_pace_ctrl_bcd_counter4.sv
// 4-digit BCD incrementer with synchronous clear, enable and saturation at 9999.
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [15:0] o_count
);

  logic [15:0] r_cnt;
  logic [15:0] w_nxt;
  logic        w_sat;

  assign w_sat = (r_cnt == 16'h9999);

  always_comb begin
    logic carry;
    w_nxt = r_cnt;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r_cnt[i*4 +: 4] == 4'd9) begin
          w_nxt[i*4 +: 4] = 4'd0;
        end else begin
          w_nxt[i*4 +: 4] = r_cnt[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= 16'h0000;
    else if (i_clr)            r_cnt <= 16'h0000;
    else if (i_en && !w_sat)   r_cnt <= w_nxt;
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/game_pace_ctrl.sv
// Game state machine and per-frame sequencer for scroll position, speed ramp
// and score; frame ticks are falling edges of fresh.
module game_pace_ctrl
  import game_defs::*;
#(
  parameter int GROUND_LEN   = GROUND_LEN_DEF,
  parameter int SPEED_INIT   = 1,
  parameter int SPEED_MAX    = SPEED_MAX_DEF,
  parameter int RAMP_FRAMES  = 600,
  parameter int SCORE_FRAMES = 6,
  parameter int OVER_HOLD    = 60
) (
  input  logic       clk,
  input  logic       N_rst,
  game_pace_if.slave bus
);

  localparam int RW = (RAMP_FRAMES  > 1) ? $clog2(RAMP_FRAMES)  : 1;
  localparam int SW = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
  localparam int HW = $clog2(OVER_HOLD + 1);

  localparam logic [3:0]    SPD_INIT = 4'(SPEED_INIT);
  localparam logic [3:0]    SPD_MAX  = 4'(SPEED_MAX);
  localparam logic [8:0]    GLEN     = 9'(GROUND_LEN);
  localparam logic [RW-1:0] RAMP_END = RW'(RAMP_FRAMES - 1);
  localparam logic [SW-1:0] SC_END   = SW'(SCORE_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_END = HW'(OVER_HOLD);

  state_t        r_state, w_state_nxt;
  logic          r_fresh_d;
  logic          r_start_d;
  logic [7:0]    r_pos;
  logic [3:0]    r_speed;
  logic [RW-1:0] r_ramp;
  logic [SW-1:0] r_sc;
  logic [HW-1:0] r_hold;

  logic w_tick, w_start_pulse, w_hold_done;
  logic w_load, w_adv, w_hold_clr, w_hold_inc;
  logic w_status, w_over;
  logic w_ramp_wrap, w_sc_wrap;

  assign w_tick        = r_fresh_d & ~bus.fresh;
  assign w_start_pulse = bus.start & ~r_start_d;
  assign w_hold_done   = (r_hold == HOLD_END);
  assign w_ramp_wrap   = (r_ramp == RAMP_END);
  assign w_sc_wrap     = (r_sc == SC_END);

  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      r_state   <= ST_IDLE;
      r_fresh_d <= 1'b1;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fresh_d <= bus.fresh;
      r_start_d <= bus.start;
    end
  end

  // Collision is checked before tick so an overlapping frame never advances.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_hold_clr  = 1'b0;
    w_hold_inc  = 1'b0;
    w_status    = 1'b0;
    w_over      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_pulse) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        w_status = 1'b1;
        if (bus.collision) begin
          w_state_nxt = ST_OVER;
          w_hold_clr  = 1'b1;
        end else if (w_tick) begin
          w_adv = 1'b1;
        end
      end
      ST_OVER: begin
        w_over = 1'b1;
        if (w_hold_done && w_start_pulse) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else if (w_tick && !w_hold_done) begin
          w_hold_inc = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      r_pos   <= 8'd0;
      r_speed <= SPD_INIT;
      r_ramp  <= '0;
      r_sc    <= '0;
    end else if (w_load) begin
      r_pos   <= 8'd0;
      r_speed <= SPD_INIT;
      r_ramp  <= '0;
      r_sc    <= '0;
    end else if (w_adv) begin
      r_pos <= wrap_add(r_pos, r_speed, GLEN);
      if (w_ramp_wrap) begin
        r_ramp <= '0;
        if (r_speed < SPD_MAX) r_speed <= r_speed + 4'd1;
      end else begin
        r_ramp <= r_ramp + 1'b1;
      end
      r_sc <= w_sc_wrap ? '0 : r_sc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst)          r_hold <= '0;
    else if (w_hold_clr) r_hold <= '0;
    else if (w_hold_inc) r_hold <= r_hold + 1'b1;
  end

  bcd_counter4 u_score (
    .clk     (clk),
    .rst_n   (N_rst),
    .i_clr   (w_load),
    .i_en    (w_adv & w_sc_wrap),
    .o_count (bus.score)
  );

  assign bus.game_status     = w_status;
  assign bus.game_over       = w_over;
  assign bus.ground_position = r_pos;
  assign bus.speed           = r_speed;

endmodule

// File: doc/game_pace_ctrl.md
Name: game_pace_ctrl

Overview:
Central pacing controller for the scrolling dinosaur game.
- Owns the game state machine (idle, running, over) and the `game_status` flag consumed by the ground and obstacle renderers.
- Once per displayed frame, on the falling edge of `fresh`, it advances the shared ground scroll position by the current speed.
- Ramps speed with elapsed frames and keeps a 4-digit BCD score.
- Replaces the per-renderer free-running position/speed registers with one sequenced source.

Parameters:
- GROUND_LEN, 160, scroll period in pixels; position wraps modulo this value.
- SPEED_INIT, 1, speed loaded on every new game.
- SPEED_MAX, 8, speed saturation value (must be ≤ 15).
- RAMP_FRAMES, 600, running frames between speed increments.
- SCORE_FRAMES, 6, running frames per score increment.
- OVER_HOLD, 60, frames in OVER before `start` is accepted again.

Ports:
- clk  in  1  system clock (clkdiv[0] domain).
- N_rst  in  1  asynchronous active-low reset.
- fresh  in  1  frame strobe from VGA timing, synchronous to clk; a frame tick is its falling edge.
- start  in  1  start/jump key level, synchronous.
- collision  in  1  dinosaur/obstacle overlap flag, synchronous.
- game_status  out  1  1 in RUN, 0 otherwise.
- game_over  out  1  1 in OVER.
- ground_position  out  8  scroll offset, 0..GROUND_LEN-1.
- speed  out  4  pixels advanced per frame.
- score  out  16  BCD, 4 digits.

Behaviour:
- Reset (N_rst low, async): state=IDLE, ground_position=0, speed=SPEED_INIT, score=0, game_status=0, game_over=0, all internal counters 0, fresh_d=1.
- Frame tick: fresh_d <= fresh every cycle; tick = fresh_d & ~fresh.
  - All per-frame updates happen on the clock edge that samples tick, so outputs change one cycle after `fresh` is seen low.
- Start detection: start_d register; start_pulse = start & ~start_d. A held key yields one pulse.
- IDLE:
  - game_status=0; position frozen.
  - On start_pulse: go to RUN, load speed=SPEED_INIT, score=0, ground_position=0, frame counters=0.
- RUN:
  - game_status=1.
  - On tick: ground_position <= pos+speed ≥ GROUND_LEN ? pos+speed-GROUND_LEN : pos+speed. One conditional subtract suffices because pos+speed < 2*GROUND_LEN; compute in 9 bits.
  - Ramp counter: increments on each tick. When it reaches RAMP_FRAMES-1 it clears and speed <= min(speed+1, SPEED_MAX).
  - Score counter: increments on each tick. When it reaches SCORE_FRAMES-1 it clears and score increments in BCD with per-digit carry; saturates at 9999.
  - collision=1 → go to OVER on that edge.
- Collision and tick in the same cycle: collision wins. No position, speed or score update on that edge.
- start_pulse in RUN: ignored (the jump logic elsewhere consumes it).
- OVER:
  - game_status=0, game_over=1; position, speed and score hold their final values for display.
  - Hold counter counts ticks up to OVER_HOLD; start_pulse before then is ignored.
  - After the hold: start_pulse → RUN with the same reloads as from IDLE.
- Reset mid-game: asynchronous return to the reset values above, regardless of state.
- Unused state encoding → IDLE.

Decomposition:
- Shared package/header `game_defs`: state encodings (IDLE=2'd0, RUN=2'd1, OVER=2'd2), GROUND_LEN, SPEED_MAX default. The same GROUND_LEN is used by the ground renderer.
- One sub-module, `bcd_counter4`: 4-digit BCD incrementer with enable, clear and saturate at 9999.

Test Plan:
- Reset, then 3 fresh falling edges with no start → state IDLE, ground_position=0, speed=1, game_status=0.
- start pulse, then 5 ticks → game_status=1, ground_position=5; score=0 after 5 ticks, score=0x0001 after the 6th tick.
- Force speed=7 and position=155, one tick → ground_position=2 (wrap); position=153, speed=7 → 0.
- Run 600 ticks → speed=2; run to speed 8, then a further 600 ticks → speed stays 8.
- collision asserted in the same cycle as a tick at position=40 → game_over=1, position stays 40. start at hold frame 10 ignored; start after 60 ticks → RUN, position=0, score=0, speed=1.
- Hold start high across the transition into RUN → exactly one start pulse; N_rst low mid-RUN → outputs return to reset values asynchronously.
